// File: rtl/pll_rst_ctrl_pkg.sv
// Shared definitions for the PLL reset/lock sequencer: state encoding, field widths, saturating helper.
package pll_rst_ctrl_pkg;

  localparam int RETRY_W = 3;
  localparam int LOSS_W  = 8;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [LOSS_W-1:0] loss_inc(input logic [LOSS_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pll_rst_ctrl_sync.sv
// Two-flop bit synchroniser, clears to 0 on the synchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic ff1_q, ff1_d;
  logic ff2_q, ff2_d;

  always_comb begin
    ff1_d = d;
    ff2_d = ff1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      ff1_q <= ff1_d;
      ff2_q <= ff2_d;
    end
  end

  assign q = ff2_q;

endmodule

// File: rtl/pll_rst_ctrl.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for and qualifies lock, then releases rst_out.
// Optional lock-loss event counter enabled by defining PLL_RST_CTRL_LOSS_CNT_EN.
module pll_rst_ctrl
  import pll_rst_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 4,
  parameter int CNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_lock,
  output logic               pll_rst,
  output logic               rst_out,
  output logic               ready,
  output logic               fail,
`ifdef PLL_RST_CTRL_LOSS_CNT_EN
  output logic [LOSS_W-1:0]  loss_cnt,
`endif
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pll_rst_q, pll_rst_d;
  logic               rst_out_q, rst_out_d;
  logic               ready_q, ready_d;
  logic               fail_q, fail_d;
`ifdef PLL_RST_CTRL_LOSS_CNT_EN
  logic [LOSS_W-1:0]  loss_q, loss_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
`ifdef PLL_RST_CTRL_LOSS_CNT_EN
    loss_d  = loss_q;
`endif
    case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_inc(retry_q);
          cnt_d   = '0;
          state_d = (int'(retry_d) == MAX_RETRY) ? ST_FAIL : ST_RESET_PLL;
        end
      end
      ST_STABLE: begin
        // Any low synced sample restarts qualification; it is not counted as a retry.
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d = ST_RESET_PLL;
          retry_d = '0;
`ifdef PLL_RST_CTRL_LOSS_CNT_EN
          loss_d  = loss_inc(loss_q);
`endif
        end
      end
      ST_FAIL: begin
        cnt_d = '0;
      end
      default: begin
        state_d = ST_RESET_PLL;
        cnt_d   = '0;
      end
    endcase

    // Outputs decode the next state so they change on the same edge as the state register.
    pll_rst_d = (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
    rst_out_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
    fail_d    = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      rst_out_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
`ifdef PLL_RST_CTRL_LOSS_CNT_EN
      loss_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
`ifdef PLL_RST_CTRL_LOSS_CNT_EN
      loss_q    <= loss_d;
`endif
    end
  end

  assign pll_rst   = pll_rst_q;
  assign rst_out   = rst_out_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
`ifdef PLL_RST_CTRL_LOSS_CNT_EN
  assign loss_cnt  = loss_q;
`endif

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Directed bench for pll_rst_ctrl with scaled timing (RST=4, TIMEOUT=20, STABLE=8, MAX_RETRY=2).
module tb_pll_rst_ctrl;

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic       pll_rst;
  logic       rst_out;
  logic       ready;
  logic       fail;
  logic [2:0] retry_cnt;
`ifdef PLL_RST_CTRL_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int low_run = 0;

  pll_rst_ctrl #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRY     (2),
    .CNT_W         (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pll_lock  (pll_lock),
    .pll_rst   (pll_rst),
    .rst_out   (rst_out),
    .ready     (ready),
    .fail      (fail),
`ifdef PLL_RST_CTRL_LOSS_CNT_EN
    .loss_cnt  (loss_cnt),
`endif
    .retry_cnt (retry_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver: advance n edges, land 1 time unit after the edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"}, {7'd0, pll_rst}, 8'd1);
    chk({tag, "_rst_out"}, {7'd0, rst_out}, 8'd1);
    chk({tag, "_ready"},   {7'd0, ready},   8'd0);
    chk({tag, "_fail"},    {7'd0, fail},    8'd0);
    chk({tag, "_retry"},   {5'd0, retry_cnt}, 8'd0);
  endtask

  // release must imply ready, and must not survive a synced-low lock beyond 3 cycles
  always @(negedge clk) begin
    if (pll_lock === 1'b0) low_run = low_run + 1;
    else low_run = 0;
    if (rst_out === 1'b0) begin
      chk("inv_ready_when_released", {7'd0, ready}, 8'd1);
      chk("inv_lock_low_while_released", {7'd0, (low_run > 3)}, 8'd0);
    end
  end

  initial begin
    rst = 1'b1;
    pll_lock = 1'b0;
    tick(3);
    chk_reset_vals("reset");
`ifdef PLL_RST_CTRL_LOSS_CNT_EN
    chk("reset_loss_cnt", loss_cnt, 8'd0);
`endif

    // clean start: pll_rst held 4 cycles counting the last reset edge
    rst = 1'b0;
    tick(3);
    chk("clean_pll_rst_held", {7'd0, pll_rst}, 8'd1);
    tick(1);
    chk("clean_pll_rst_fall", {7'd0, pll_rst}, 8'd0);
    tick(10);
    pll_lock = 1'b1;
    // lock seen by FSM 2 edges later, STABLE for 8, release on the 11th edge
    tick(10);
    chk("clean_pre_release_rst_out", {7'd0, rst_out}, 8'd1);
    chk("clean_pre_release_ready", {7'd0, ready}, 8'd0);
    tick(1);
    chk("clean_release_rst_out", {7'd0, rst_out}, 8'd0);
    chk("clean_release_ready", {7'd0, ready}, 8'd1);
    chk("clean_retry", {5'd0, retry_cnt}, 8'd0);
    chk("clean_pll_rst_low", {7'd0, pll_rst}, 8'd0);

    // lock loss in RUN: one-cycle drop
    tick(5);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(1);
    chk("loss_rst_out_still_low", {7'd0, rst_out}, 8'd0);
    tick(1);
    chk("loss_rst_out", {7'd0, rst_out}, 8'd1);
    chk("loss_ready", {7'd0, ready}, 8'd0);
    chk("loss_pll_rst", {7'd0, pll_rst}, 8'd1);
    chk("loss_retry", {5'd0, retry_cnt}, 8'd0);
`ifdef PLL_RST_CTRL_LOSS_CNT_EN
    chk("loss_cnt_one", loss_cnt, 8'd1);
`endif
    tick(3);
    chk("loss_pll_rst_held", {7'd0, pll_rst}, 8'd1);
    tick(1);
    chk("loss_pll_rst_fall", {7'd0, pll_rst}, 8'd0);
    tick(8);
    chk("loss_pre_rerelease", {7'd0, rst_out}, 8'd1);
    tick(1);
    chk("loss_rerelease", {7'd0, rst_out}, 8'd0);
    chk("loss_rerelease_ready", {7'd0, ready}, 8'd1);

    // rst while in RUN aborts to reset values
    rst = 1'b1;
    pll_lock = 1'b0;
    tick(1);
    chk_reset_vals("rst_in_run");
`ifdef PLL_RST_CTRL_LOSS_CNT_EN
    chk("rst_clears_loss_cnt", loss_cnt, 8'd0);
`endif
    tick(1);
    rst = 1'b0;

    // glitching lock: high 5, low 1, then steady
    tick(4);
    chk("glitch_wait_entry", {7'd0, pll_rst}, 8'd0);
    tick(2);
    pll_lock = 1'b1;
    tick(5);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(9);
    chk("glitch_no_early_release", {7'd0, rst_out}, 8'd1);
    tick(1);
    chk("glitch_pre_release", {7'd0, rst_out}, 8'd1);
    tick(1);
    chk("glitch_release", {7'd0, rst_out}, 8'd0);
    chk("glitch_ready", {7'd0, ready}, 8'd1);
    chk("glitch_retry", {5'd0, retry_cnt}, 8'd0);

    // rst asserted during STABLE
    rst = 1'b1;
    pll_lock = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(4);
    chk("stable_setup_wait", {7'd0, pll_rst}, 8'd0);
    pll_lock = 1'b1;
    tick(5);
    chk("stable_setup_not_released", {7'd0, rst_out}, 8'd1);
    rst = 1'b1;
    tick(1);
    chk_reset_vals("rst_in_stable");
    rst = 1'b0;
    tick(3);
    chk("stable_restart_pll_rst", {7'd0, pll_rst}, 8'd1);
    tick(1);
    chk("stable_restart_wait", {7'd0, pll_rst}, 8'd0);
    // sync cleared by rst: FSM sees lock 1 edge into WAIT_LOCK, then 8 STABLE cycles
    tick(9);
    chk("stable_restart_release", {7'd0, rst_out}, 8'd0);

    // lock never comes
    rst = 1'b1;
    pll_lock = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(4);
    chk("nolock_wait1", {7'd0, pll_rst}, 8'd0);
    tick(19);
    chk("nolock_wait1_end", {7'd0, pll_rst}, 8'd0);
    chk("nolock_wait1_retry", {5'd0, retry_cnt}, 8'd0);
    tick(1);
    chk("nolock_pulse2", {7'd0, pll_rst}, 8'd1);
    chk("nolock_retry1", {5'd0, retry_cnt}, 8'd1);
    chk("nolock_not_failed", {7'd0, fail}, 8'd0);
    tick(3);
    chk("nolock_pulse2_held", {7'd0, pll_rst}, 8'd1);
    tick(1);
    chk("nolock_wait2", {7'd0, pll_rst}, 8'd0);
    tick(19);
    chk("nolock_wait2_end_fail", {7'd0, fail}, 8'd0);
    tick(1);
    chk("nolock_fail", {7'd0, fail}, 8'd1);
    chk("nolock_fail_pll_rst", {7'd0, pll_rst}, 8'd1);
    chk("nolock_fail_rst_out", {7'd0, rst_out}, 8'd1);
    chk("nolock_fail_ready", {7'd0, ready}, 8'd0);
    chk("nolock_fail_retry", {5'd0, retry_cnt}, 8'd2);
    // lock arriving late must not leave FAIL
    pll_lock = 1'b1;
    tick(30);
    chk("fail_sticky", {7'd0, fail}, 8'd1);
    chk("fail_sticky_rst_out", {7'd0, rst_out}, 8'd1);
    chk("fail_sticky_pll_rst", {7'd0, pll_rst}, 8'd1);

    // rst asserted in FAIL
    rst = 1'b1;
    tick(1);
    chk_reset_vals("rst_in_fail");
    rst = 1'b0;
    tick(3);
    chk("fail_restart_pll_rst", {7'd0, pll_rst}, 8'd1);
    tick(1);
    chk("fail_restart_wait", {7'd0, pll_rst}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
